// File: rtl/fpdiv_share_ctrl.sv
// fpdiv_share_ctrl
// Shares one combinational IEEE-754 double divider among NREQ requesters.
// A round-robin arbiter accepts one division at a time. The operands are
// registered and then held for SETTLE cycles so the divider is a multicycle
// path. The quotient is then captured and returned to the owning requester
// together with an advisory divide-by-zero flag.

module fpdiv_share_ctrl #(
    parameter int NREQ   = 2,
    parameter int SETTLE = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_n1,
    input  logic [64*NREQ-1:0]   req_n2,
    output logic [63:0]          div_n1,
    output logic [63:0]          div_n2,
    input  logic [63:0]          div_out,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [63:0]          resp_data,
    output logic                 resp_dz,
    output logic                 busy
);

    localparam int TW = $clog2(NREQ);
    localparam int CW = $clog2(SETTLE) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] tag;
    logic [CW-1:0] cnt;

    logic [TW-1:0] grant_idx;
    logic          grant_any;
    logic [63:0]   sel_n1;
    logic [63:0]   sel_n2;
    logic          sel_dz;
    logic          accept;
    logic          resp_take;
    logic [TW-1:0] next_rr;

    // Add an offset to a requester index, wrapping modulo NREQ.
    function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return s[TW-1:0];
    endfunction

    // Pick the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[wrap_add(rr_ptr, k)]) begin
                grant_idx = wrap_add(rr_ptr, k);
                grant_any = 1'b1;
            end
        end
    end

    // Select the granted operands and classify divide-by-zero (finite nonzero / zero).
    always_comb begin
        sel_n1 = req_n1[int'(grant_idx)*64 +: 64];
        sel_n2 = req_n2[int'(grant_idx)*64 +: 64];
        sel_dz = (sel_n2[62:0] == 63'd0) &&
                 (sel_n1[62:52] != 11'h7ff) &&
                 (sel_n1[62:0] != 63'd0);
    end

    // Handshake qualifiers, one-hot grant and response strobes; all quiet during reset.
    always_comb begin
        accept     = (state == S_IDLE) && grant_any && rst_n;
        resp_take  = (state == S_RESP) && resp_ready[tag];
        next_rr    = (tag == TW'(NREQ - 1)) ? '0 : tag + TW'(1);
        req_ready  = '0;
        resp_valid = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state == S_RESP) begin
            resp_valid[tag] = 1'b1;
        end
        busy = (state != S_IDLE);
    end

    // Controller state, operand registers, settle counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            tag       <= '0;
            cnt       <= '0;
            div_n1    <= '0;
            div_n2    <= '0;
            resp_data <= '0;
            resp_dz   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_n1  <= sel_n1;
                        div_n2  <= sel_n2;
                        resp_dz <= sel_dz;
                        tag     <= grant_idx;
                        cnt     <= CW'(SETTLE - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        resp_data <= div_out;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_take) begin
                        rr_ptr <= next_rr;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpdiv_share_ctrl.sv
// tb_fpdiv_share_ctrl
// Directed bench for the shared divider controller with two requesters and
// SETTLE=3. The divider is a lookup table of hand-computed quotients.

module tb_fpdiv_share_ctrl;

    localparam int NREQ   = 2;
    localparam int SETTLE = 3;

    localparam logic [63:0] D_12_5 = 64'h4029000000000000;
    localparam logic [63:0] D_10   = 64'h4024000000000000;
    localparam logic [63:0] D_1_25 = 64'h3ff4000000000000;
    localparam logic [63:0] D_1    = 64'h3ff0000000000000;
    localparam logic [63:0] D_2    = 64'h4000000000000000;
    localparam logic [63:0] D_0_5  = 64'h3fe0000000000000;
    localparam logic [63:0] D_28   = 64'h403c000000000000;
    localparam logic [63:0] D_14   = 64'h402c000000000000;
    localparam logic [63:0] D_M5   = 64'hc014000000000000;
    localparam logic [63:0] D_ZERO = 64'h0000000000000000;
    localparam logic [63:0] D_NINF = 64'hfff0000000000000;
    localparam logic [63:0] D_QNAN = 64'h7ff8000000000000;
    localparam logic [63:0] D_JUNK = 64'hdeadbeefcafef00d;
    localparam logic [63:0] D_DFLT = 64'h123456789abcdef0;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [64*NREQ-1:0]   req_n1;
    logic [64*NREQ-1:0]   req_n2;
    logic [63:0]          div_n1;
    logic [63:0]          div_n2;
    logic [63:0]          div_out;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [63:0]          resp_data;
    logic                 resp_dz;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    fpdiv_share_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_n1     (req_n1),
        .req_n2     (req_n2),
        .div_n1     (div_n1),
        .div_n2     (div_n2),
        .div_out    (div_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_dz    (resp_dz),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: known quotients for the operand pairs used below.
    always_comb begin
        case ({div_n1, div_n2})
            {D_12_5, D_10}:   div_out = D_1_25;
            {D_1,    D_2}:    div_out = D_0_5;
            {D_28,   D_2}:    div_out = D_14;
            {D_M5,   D_ZERO}: div_out = D_NINF;
            {D_ZERO, D_ZERO}: div_out = D_QNAN;
            default:          div_out = D_DFLT;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] valid,
                                  input logic [63:0] a0, input logic [63:0] b0,
                                  input logic [63:0] a1, input logic [63:0] b1);
        req_valid = valid;
        req_n1    = {a1, a0};
        req_n2    = {b1, b0};
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0]  exp_gnt;
        logic [63:0] exp_n1;
        logic [63:0] exp_q;

        // Reset, with a request pending to show req_ready is held low
        rst_n      = 1'b0;
        resp_ready = 2'b00;
        apply_stimulus(2'b11, D_1, D_2, D_28, D_2);
        step();
        step();
        check_output("rst_req_ready",  64'(req_ready),  64'd0);
        check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_output("rst_busy",       64'(busy),       64'd0);
        check_output("rst_div_n1",     div_n1,          64'd0);
        check_output("rst_div_n2",     div_n2,          64'd0);
        check_output("rst_resp_data",  resp_data,       64'd0);
        check_output("rst_resp_dz",    64'(resp_dz),    64'd0);
        apply_stimulus(2'b00, D_ZERO, D_ZERO, D_ZERO, D_ZERO);
        rst_n = 1'b1;
        step();

        // Single request 12.5/10 from requester 0, with operand churn during WAIT
        $display("[TB] single request");
        apply_stimulus(2'b01, D_12_5, D_10, D_ZERO, D_ZERO);
        #1;
        check_output("single_req_ready", 64'(req_ready), 64'd1);
        check_output("single_idle_busy", 64'(busy),      64'd0);
        step();
        check_output("single_busy",      64'(busy),      64'd1);
        check_output("single_div_n1",    div_n1,         D_12_5);
        check_output("single_div_n2",    div_n2,         D_10);
        check_output("single_ready_off", 64'(req_ready), 64'd0);
        apply_stimulus(2'b00, D_JUNK, D_JUNK, D_ZERO, D_ZERO);
        for (int i = 1; i < SETTLE; i++) begin
            step();
            check_output("single_wait_valid", 64'(resp_valid), 64'd0);
            check_output("single_hold_n1",    div_n1,          D_12_5);
            check_output("single_hold_n2",    div_n2,          D_10);
        end
        step();
        check_output("single_resp_valid", 64'(resp_valid), 64'd1);
        check_output("single_resp_data",  resp_data,        D_1_25);
        check_output("single_resp_dz",    64'(resp_dz),     64'd0);
        check_output("single_cap_n1",     div_n1,           D_12_5);
        resp_ready = 2'b01;
        step();
        check_output("single_back_busy",  64'(busy),       64'd0);
        check_output("single_back_valid", 64'(resp_valid), 64'd0);

        // Backpressure on requester 1 while requester 0 waits for a grant
        $display("[TB] backpressure");
        apply_stimulus(2'b10, D_ZERO, D_ZERO, D_28, D_2);
        #1;
        check_output("bp_req_ready", 64'(req_ready), 64'd2);
        step();
        check_output("bp_div_n1", div_n1, D_28);
        apply_stimulus(2'b01, D_1, D_2, D_28, D_2);
        resp_ready = 2'b01;
        for (int i = 0; i < SETTLE; i++) begin
            step();
        end
        for (int i = 0; i < 5; i++) begin
            check_output("bp_resp_valid", 64'(resp_valid), 64'd2);
            check_output("bp_resp_data",  resp_data,        D_14);
            check_output("bp_resp_dz",    64'(resp_dz),     64'd0);
            check_output("bp_req_ready",  64'(req_ready),   64'd0);
            check_output("bp_busy",       64'(busy),        64'd1);
            step();
        end
        resp_ready = 2'b10;
        #1;
        check_output("bp_ready_before_take", 64'(req_ready), 64'd0);
        step();
        check_output("bp_after_valid", 64'(resp_valid), 64'd0);
        check_output("bp_after_busy",  64'(busy),       64'd0);
        check_output("bp_next_grant",  64'(req_ready),  64'd1);
        apply_stimulus(2'b00, D_ZERO, D_ZERO, D_ZERO, D_ZERO);
        step();

        // Round robin with both requesters continuously valid
        $display("[TB] round robin");
        apply_stimulus(2'b11, D_1, D_2, D_28, D_2);
        resp_ready = 2'b11;
        #1;
        for (int r = 0; r < 4; r++) begin
            exp_gnt = (r % 2 == 0) ? 2'b01 : 2'b10;
            exp_n1  = (r % 2 == 0) ? D_1 : D_28;
            exp_q   = (r % 2 == 0) ? D_0_5 : D_14;
            check_output("rr_grant", 64'(req_ready), 64'(exp_gnt));
            step();
            check_output("rr_div_n1", div_n1, exp_n1);
            for (int i = 0; i < SETTLE; i++) begin
                step();
            end
            check_output("rr_resp_valid", 64'(resp_valid), 64'(exp_gnt));
            check_output("rr_resp_data",  resp_data,        exp_q);
            step();
            if (r == 3) begin
                apply_stimulus(2'b00, D_ZERO, D_ZERO, D_ZERO, D_ZERO);
            end
            #1;
        end

        // Divide-by-zero from requester 1, then 0/0 from requester 0
        $display("[TB] divide by zero");
        apply_stimulus(2'b10, D_ZERO, D_ZERO, D_M5, D_ZERO);
        step();
        apply_stimulus(2'b00, D_ZERO, D_ZERO, D_ZERO, D_ZERO);
        for (int i = 0; i < SETTLE; i++) begin
            step();
        end
        check_output("dz_resp_valid", 64'(resp_valid), 64'd2);
        check_output("dz_resp_data",  resp_data,        D_NINF);
        check_output("dz_flag",       64'(resp_dz),     64'd1);
        step();
        apply_stimulus(2'b01, D_ZERO, D_ZERO, D_ZERO, D_ZERO);
        #1;
        check_output("zz_grant", 64'(req_ready), 64'd1);
        step();
        apply_stimulus(2'b00, D_ZERO, D_ZERO, D_ZERO, D_ZERO);
        for (int i = 0; i < SETTLE; i++) begin
            step();
        end
        check_output("zz_resp_valid", 64'(resp_valid), 64'd1);
        check_output("zz_resp_data",  resp_data,        D_QNAN);
        check_output("zz_flag",       64'(resp_dz),     64'd0);
        step();

        // Reset during the second settle cycle discards the division
        $display("[TB] reset mid-wait");
        apply_stimulus(2'b01, D_12_5, D_10, D_ZERO, D_ZERO);
        step();
        check_output("mid_busy", 64'(busy), 64'd1);
        step();
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy",      64'(busy),       64'd0);
        check_output("mid_rst_req_ready", 64'(req_ready),  64'd0);
        check_output("mid_rst_div_n1",    div_n1,          64'd0);
        check_output("mid_rst_div_n2",    div_n2,          64'd0);
        check_output("mid_rst_resp_data", resp_data,       64'd0);
        check_output("mid_rst_resp_dz",   64'(resp_dz),    64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("mid_rst_no_resp", 64'(resp_valid), 64'd0);
        end
        apply_stimulus(2'b11, D_1, D_2, D_28, D_2);
        rst_n = 1'b1;
        #1;
        check_output("mid_after_grant", 64'(req_ready), 64'd1);
        step();
        check_output("mid_after_div_n1", div_n1, D_1);
        apply_stimulus(2'b00, D_ZERO, D_ZERO, D_ZERO, D_ZERO);
        for (int i = 0; i < SETTLE; i++) begin
            check_output("mid_after_no_resp", 64'(resp_valid), 64'd0);
            step();
        end
        check_output("mid_after_resp_valid", 64'(resp_valid), 64'd1);
        check_output("mid_after_resp_data",  resp_data,        D_0_5);
        step();
        check_output("mid_after_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpdiv_share_ctrl.md
# fpdiv_share_ctrl

Round-robin controller that shares one 64-bit combinational FP divider (N1/N2 → out, IEEE-754 double) among NREQ requesters. It accepts one division at a time over a valid/ready handshake and drives registered operands into the divider. It waits a fixed number of settle cycles so the divider is a multicycle path, then captures the quotient and returns it with a requester tag. It sits between the FPU issue logic and the divider instance.

## Interface
- NREQ, 2: number of requesters, 2..8.
- SETTLE, 3: cycles the divider inputs are held stable before the quotient is captured, ≥1.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant/accept.
- req_n1  in  64*NREQ  dividend, requester i at [64i+63:64i].
- req_n2  in  64*NREQ  divisor, same packing.
- div_n1  out  64  registered dividend to divider.
- div_n2  out  64  registered divisor to divider.
- div_out  in  64  divider quotient (combinational from div_n1/div_n2).
- resp_valid  out  NREQ  one-hot result valid to owning requester.
- resp_ready  in  NREQ  per-requester result accept.
- resp_data  out  64  captured quotient.
- resp_dz  out  1  divide-by-zero flag: N2 exponent and mantissa zero, N1 finite and nonzero.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching from rr_ptr upward and wrapping mod NREQ.
  - req_ready[g]=1 combinationally. req_ready is 0 in every other state.
  - On the handshake edge: latch req_n1[g] and req_n2[g] into div_n1/div_n2, tag←g, cnt←SETTLE-1, dz←flag computed from the latched operands, go WAIT.
- WAIT:
  - div_n1/div_n2 held constant.
  - If cnt==0: resp_data←div_out, go RESP. Otherwise cnt←cnt-1.
- RESP:
  - resp_valid[tag]=1, resp_dz valid.
  - Hold resp_data, resp_dz and the one-hot position until resp_ready[tag]=1.
  - On that edge: rr_ptr←(tag+1) mod NREQ, go IDLE.
  - resp_ready of other requesters is ignored.
- The controller never alters div_out. NaN/inf/zero results pass through unchanged; resp_dz is advisory only.
- Requests that are not granted must keep req_valid and operands stable. The controller takes no action on a withdrawn request.
- tag width is clog2(NREQ). cnt width is clog2(SETTLE)+1.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, rr_ptr=0, tag=0, cnt=0.
  - div_n1=div_n2=resp_data=0, resp_dz=0.
  - req_ready=0 while rst_n=0; resp_valid=0; busy=0.
- Reset mid-operation discards the in-flight division. No response is produced. Normal operation resumes at the first clock edge after rst_n deasserts.
- Latency: handshake at edge E0 → quotient captured at edge E0+SETTLE → resp_valid high from E0+SETTLE. Each additional cycle with resp_ready low adds one cycle.
- Throughput: with resp_ready tied high, one division per SETTLE+2 cycles (accept, SETTLE settle cycles, RESP, back in IDLE). No new grant is issued while busy.
- Fairness: the requester just served has lowest priority next. With all req_valid high, grants rotate 0,1,…,NREQ-1,0.
- Simultaneous events:
  - resp_ready in RESP together with new req_valid: the new request is granted in the following IDLE cycle, not the same cycle.
  - rst_n falling in the same cycle as a handshake: reset wins.

## Test plan
- Single request: requester 0 sends 0x4029000000000000 / 0x4024000000000000 (12.5/10), SETTLE=3. Required: resp_valid[0] exactly 3 cycles after the accept edge, resp_data=0x3ff4000000000000, resp_dz=0.
- Round-robin: both requesters hold valid continuously. Requester 0 sends 1.0/2.0 (0x3ff0…/0x4000…); requester 1 sends 28/2 (0x403c…/0x4000…). Required:
  - grants alternate 0,1,0,1;
  - responses 0x3fe0000000000000 to requester 0 and 0x402c000000000000 to requester 1;
  - resp_valid one-hot and matching the tag.
- Backpressure: hold resp_ready[1] low for 5 cycles. Required: resp_data, resp_dz and resp_valid[1] stable for those cycles; req_ready stays 0; busy=1; the next grant occurs only after the accepting edge.
- Divide-by-zero: 0xc014000000000000 / 0x0000000000000000. Required: resp_dz=1 and resp_data equals the divider output unchanged (0xfff0000000000000). Also 0/0 → resp_dz=0.
- Reset mid-WAIT: assert rst_n low during the second settle cycle. Required: all outputs take their reset values immediately, no resp_valid appears afterward, and the next request is served by requester-0-first priority.
- Operand stability: check div_n1/div_n2 are constant from the accept edge through capture, and that a change on req_n1/req_n2 during WAIT does not alter resp_data.
